// File: rtl/snn_window_ctrl.sv
// Evaluation-window controller for a two-layer spiking classifier: captures a pixel,
// pulses neuron/encoder resets, counts output spikes over STEPS+DRAIN_CYC cycles and reports a class.
module snn_window_ctrl #(
   parameter int unsigned STEPS            = 50,
   parameter int unsigned DRAIN_CYC        = 2,
   parameter int unsigned N_SP_TO_ACTIVATE = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pix_valid,
   output logic       pix_ready,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   output logic [7:0] r_hold,
   output logic [7:0] g_hold,
   output logic [7:0] b_hold,
   output logic       enc_reset,
   output logic       res_ly_1,
   output logic       res_ly_2,
   input  logic       out_0,
   input  logic       out_1,
   output logic       cls_valid,
   output logic [1:0] cls,
   output logic [7:0] cnt0,
   output logic [7:0] cnt1
);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, REPORT} state_e;

   localparam logic [7:0] LAST_STEP  = 8'(STEPS - 1);
   localparam logic [3:0] LAST_DRAIN = 4'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);
   localparam bit         HAS_DRAIN  = (DRAIN_CYC != 0);

   state_e     state_q, state_d;
   logic [7:0] step_q, step_d;
   logic [3:0] drain_q, drain_d;
   logic [7:0] work0_q, work0_d;
   logic [7:0] work1_q, work1_d;
   logic [7:0] r_hold_q, r_hold_d;
   logic [7:0] g_hold_q, g_hold_d;
   logic [7:0] b_hold_q, b_hold_d;
   logic       ready_q, ready_d;
   logic       clr_q, clr_d;
   logic       cls_valid_q, cls_valid_d;
   logic [1:0] cls_q, cls_d;
   logic [7:0] cnt0_q, cnt0_d;
   logic [7:0] cnt1_q, cnt1_d;

   function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
      return (v == 8'hFF) ? v : v + 8'(inc);
   endfunction

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      drain_d  = drain_q;
      work0_d  = work0_q;
      work1_d  = work1_q;
      r_hold_d = r_hold_q;
      g_hold_d = g_hold_q;
      b_hold_d = b_hold_q;
      cls_d    = cls_q;
      cnt0_d   = cnt0_q;
      cnt1_d   = cnt1_q;

      case (state_q)
         IDLE: begin
            if (pix_valid) begin
               state_d  = CLEAR;
               r_hold_d = r_in;
               g_hold_d = g_in;
               b_hold_d = b_in;
            end
         end
         CLEAR: begin
            state_d = RUN;
            step_d  = '0;
            drain_d = '0;
            work0_d = '0;
            work1_d = '0;
         end
         RUN: begin
            work0_d = sat_inc(work0_q, out_0);
            work1_d = sat_inc(work1_q, out_1);
            if (step_q == LAST_STEP) begin
               state_d = HAS_DRAIN ? DRAIN : REPORT;
               drain_d = '0;
            end else begin
               step_d = step_q + 8'd1;
            end
         end
         DRAIN: begin
            work0_d = sat_inc(work0_q, out_0);
            work1_d = sat_inc(work1_q, out_1);
            if (drain_q == LAST_DRAIN) begin
               state_d = REPORT;
            end else begin
               drain_d = drain_q + 4'd1;
            end
         end
         REPORT: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Results are latched on the edge entering REPORT so they already include the final counting cycle.
      if (state_d == REPORT) begin
         cnt0_d = work0_d;
         cnt1_d = work1_d;
         if (32'(work0_d) >= N_SP_TO_ACTIVATE) begin
            cls_d = 2'b01;
         end else if (32'(work1_d) >= N_SP_TO_ACTIVATE) begin
            cls_d = 2'b10;
         end else begin
            cls_d = 2'b00;
         end
      end

      ready_d     = (state_d == IDLE);
      clr_d       = (state_d == CLEAR);
      cls_valid_d = (state_d == REPORT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         step_q      <= '0;
         drain_q     <= '0;
         work0_q     <= '0;
         work1_q     <= '0;
         r_hold_q    <= '0;
         g_hold_q    <= '0;
         b_hold_q    <= '0;
         ready_q     <= 1'b1;
         clr_q       <= 1'b0;
         cls_valid_q <= 1'b0;
         cls_q       <= '0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         drain_q     <= drain_d;
         work0_q     <= work0_d;
         work1_q     <= work1_d;
         r_hold_q    <= r_hold_d;
         g_hold_q    <= g_hold_d;
         b_hold_q    <= b_hold_d;
         ready_q     <= ready_d;
         clr_q       <= clr_d;
         cls_valid_q <= cls_valid_d;
         cls_q       <= cls_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

   assign pix_ready = ready_q;
   assign r_hold    = r_hold_q;
   assign g_hold    = g_hold_q;
   assign b_hold    = b_hold_q;
   assign enc_reset = clr_q;
   assign res_ly_1  = clr_q;
   assign res_ly_2  = clr_q;
   assign cls_valid = cls_valid_q;
   assign cls       = cls_q;
   assign cnt0      = cnt0_q;
   assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_snn_window_ctrl.sv
// Bench for snn_window_ctrl: three parameterisations driven with spike patterns and compared
// against a window-level reference model (latency formula, spike tallies over the counting cycles).
module tb_snn_window_ctrl;

   localparam int NSP = 5;

   logic clk = 1'b0;
   logic reset_n;
   logic       pv[3];
   logic [7:0] ri[3], gi[3], bi[3];
   logic       o0[3], o1[3];
   logic       pr[3], er[3], r1[3], r2[3], cv[3];
   logic [1:0] cl[3];
   logic [7:0] c0[3], c1[3], rh[3], gh[3], bh[3];

   int total = 0;
   int bad   = 0;

   bit s0[0:299];
   bit s1[0:299];

   int         ob_cv_cyc, ob_cv_n, ob_pulse_n, ob_rdy_bad, ob_hold_bad;
   bit         ob_pulse1, ob_rdy0, ob_rdy_after;
   logic [1:0] ob_cls, ob_cls_end;
   logic [7:0] ob_c0, ob_c1, ob_c0_end, ob_c1_end;

   always #5 clk = ~clk;

   snn_window_ctrl u_def (
      .clk(clk), .reset_n(reset_n), .pix_valid(pv[0]), .pix_ready(pr[0]),
      .r_in(ri[0]), .g_in(gi[0]), .b_in(bi[0]),
      .r_hold(rh[0]), .g_hold(gh[0]), .b_hold(bh[0]),
      .enc_reset(er[0]), .res_ly_1(r1[0]), .res_ly_2(r2[0]),
      .out_0(o0[0]), .out_1(o1[0]), .cls_valid(cv[0]), .cls(cl[0]),
      .cnt0(c0[0]), .cnt1(c1[0])
   );

   snn_window_ctrl #(.STEPS(255), .DRAIN_CYC(15)) u_big (
      .clk(clk), .reset_n(reset_n), .pix_valid(pv[1]), .pix_ready(pr[1]),
      .r_in(ri[1]), .g_in(gi[1]), .b_in(bi[1]),
      .r_hold(rh[1]), .g_hold(gh[1]), .b_hold(bh[1]),
      .enc_reset(er[1]), .res_ly_1(r1[1]), .res_ly_2(r2[1]),
      .out_0(o0[1]), .out_1(o1[1]), .cls_valid(cv[1]), .cls(cl[1]),
      .cnt0(c0[1]), .cnt1(c1[1])
   );

   snn_window_ctrl #(.STEPS(1), .DRAIN_CYC(0)) u_min (
      .clk(clk), .reset_n(reset_n), .pix_valid(pv[2]), .pix_ready(pr[2]),
      .r_in(ri[2]), .g_in(gi[2]), .b_in(bi[2]),
      .r_hold(rh[2]), .g_hold(gh[2]), .b_hold(bh[2]),
      .enc_reset(er[2]), .res_ly_1(r1[2]), .res_ly_2(r2[2]),
      .out_0(o0[2]), .out_1(o1[2]), .cls_valid(cv[2]), .cls(cl[2]),
      .cnt0(c0[2]), .cnt1(c1[2])
   );

   // Reference model: a spike driven during cycle c (handshake edge ends cycle 0) is counted
   // iff c lies in the counting span 2 .. STEPS+1+DRAIN_CYC; tallies saturate at 255.
   function automatic int exp_cnt(input bit sel, input int steps, input int drain);
      int n = 0;
      for (int c = 2; c <= steps + 1 + drain; c++) n += sel ? int'(s1[c]) : int'(s0[c]);
      return (n > 255) ? 255 : n;
   endfunction

   function automatic logic [1:0] exp_cls(input int e0, input int e1);
      if (e0 >= NSP) return 2'b01;
      if (e1 >= NSP) return 2'b10;
      return 2'b00;
   endfunction

   task automatic clear_pat();
      for (int i = 0; i < 300; i++) begin
         s0[i] = 1'b0;
         s1[i] = 1'b0;
      end
   endtask

   task automatic rand_pat(input int lo, input int hi, input int odds);
      for (int i = lo; i <= hi; i++) begin
         s0[i] = ($urandom_range(0, odds - 1) == 0);
         s1[i] = ($urandom_range(0, odds - 1) == 0);
      end
   endtask

   // Plays one window starting at the phase just after a rising edge; records observations.
   task automatic play(input int d, input int steps, input int drain, input bit noisy);
      int lim = steps + drain + 4;
      int rep = steps + 2 + drain;
      logic [23:0] cap = {ri[d], gi[d], bi[d]};
      ob_cv_cyc = -1; ob_cv_n = 0; ob_pulse_n = 0; ob_rdy_bad = 0; ob_hold_bad = 0;
      ob_pulse1 = 1'b0; ob_rdy0 = 1'b0; ob_rdy_after = 1'b0;
      ob_cls = 'x; ob_c0 = 'x; ob_c1 = 'x;
      for (int c = 0; c <= lim; c++) begin
         if (c == 0) pv[d] = 1'b1;
         else pv[d] = (noisy && c < rep) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noisy && c >= 1) begin
            ri[d] = 8'($urandom);
            gi[d] = 8'($urandom);
            bi[d] = 8'($urandom);
         end
         o0[d] = s0[c];
         o1[d] = s1[c];
         @(negedge clk);
         if (c == 0) ob_rdy0 = pr[d];
         if (c >= 1 && c <= rep && pr[d]) ob_rdy_bad++;
         if (c == rep + 1) ob_rdy_after = pr[d];
         if (er[d] || r1[d] || r2[d]) ob_pulse_n++;
         if (c == 1) ob_pulse1 = er[d] && r1[d] && r2[d];
         if (c >= 1 && {rh[d], gh[d], bh[d]} !== cap) ob_hold_bad++;
         if (cv[d]) begin
            ob_cv_n++;
            if (ob_cv_cyc < 0) begin
               ob_cv_cyc = c;
               ob_cls = cl[d];
               ob_c0 = c0[d];
               ob_c1 = c1[d];
            end
         end
         if (c == lim) begin
            ob_cls_end = cl[d];
            ob_c0_end = c0[d];
            ob_c1_end = c1[d];
         end
         @(posedge clk);
         #1;
      end
      pv[d] = 1'b0;
      o0[d] = 1'b0;
      o1[d] = 1'b0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         pv[d] = 1'b1; o0[d] = 1'b1; o1[d] = 1'b1;
         ri[d] = 8'hA5; gi[d] = 8'h5A; bi[d] = 8'h3C;
      end
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         total++; if (pr[d] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=1", d, pr[d]); end
         total++; if ({er[d], r1[d], r2[d], cv[d]} !== 4'b0) begin bad++; $display("FAIL reset_pulses[%0d] got=%b exp=0000", d, {er[d], r1[d], r2[d], cv[d]}); end
         total++; if ({cl[d], c0[d], c1[d]} !== 18'b0) begin bad++; $display("FAIL reset_result[%0d] got=%b/%0d/%0d exp=0", d, cl[d], c0[d], c1[d]); end
         total++; if ({rh[d], gh[d], bh[d]} !== 24'b0) begin bad++; $display("FAIL reset_hold[%0d] got=%h exp=0", d, {rh[d], gh[d], bh[d]}); end
      end
      for (int d = 0; d < 3; d++) begin
         pv[d] = 1'b0; o0[d] = 1'b0; o1[d] = 1'b0;
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_solid_blue();
      clear_pat();
      for (int i = 1; i < 300; i++) s0[i] = 1'b1;
      ri[0] = 8'd0; gi[0] = 8'd0; bi[0] = 8'd255;
      play(0, 50, 2, 1'b0);
      total++; if (ob_rdy0 !== 1'b1) begin bad++; $display("FAIL blue_ready_idle got=%b exp=1", ob_rdy0); end
      total++; if (ob_cv_cyc !== 54) begin bad++; $display("FAIL blue_latency got=%0d exp=54", ob_cv_cyc); end
      total++; if (ob_cv_n !== 1) begin bad++; $display("FAIL blue_strobe_width got=%0d exp=1", ob_cv_n); end
      total++; if (ob_cls !== 2'b01) begin bad++; $display("FAIL blue_cls got=%b exp=01", ob_cls); end
      total++; if (ob_c0 !== 8'(exp_cnt(0, 50, 2)) || ob_c0 !== 8'd52) begin bad++; $display("FAIL blue_cnt0 got=%0d exp=52", ob_c0); end
      total++; if (ob_c1 !== 8'd0) begin bad++; $display("FAIL blue_cnt1 got=%0d exp=0", ob_c1); end
      total++; if (ob_rdy_bad !== 0 || ob_rdy_after !== 1'b1) begin bad++; $display("FAIL blue_ready got=%0d/%b exp=0/1", ob_rdy_bad, ob_rdy_after); end
      total++; if (ob_hold_bad !== 0 || {rh[0], gh[0], bh[0]} !== 24'h0000FF) begin bad++; $display("FAIL blue_hold got=%h exp=0000ff", {rh[0], gh[0], bh[0]}); end
   endtask

   task automatic test_counts();
      int p1[5] = '{2, 11, 25, 40, 51};
      int p0[5] = '{3, 10, 20, 30, 51};
      for (int w = 0; w < 2; w++) begin
         clear_pat();
         for (int k = 0; k < 5; k++) s1[p1[k]] = 1'b1;
         for (int k = 0; k < (w == 0 ? 4 : 5); k++) s0[p0[k]] = 1'b1;
         ri[0] = 8'(w); gi[0] = 8'h80; bi[0] = 8'h10;
         play(0, 50, 2, 1'b0);
         total++; if (ob_cls !== exp_cls(exp_cnt(0, 50, 2), exp_cnt(1, 50, 2))) begin bad++; $display("FAIL counts_cls[%0d] got=%b exp=%b", w, ob_cls, exp_cls(exp_cnt(0, 50, 2), exp_cnt(1, 50, 2))); end
         total++; if (ob_c0 !== 8'(exp_cnt(0, 50, 2))) begin bad++; $display("FAIL counts_cnt0[%0d] got=%0d exp=%0d", w, ob_c0, exp_cnt(0, 50, 2)); end
         total++; if (ob_c1 !== 8'(exp_cnt(1, 50, 2))) begin bad++; $display("FAIL counts_cnt1[%0d] got=%0d exp=%0d", w, ob_c1, exp_cnt(1, 50, 2)); end
      end
   endtask

   task automatic test_saturate();
      clear_pat();
      for (int i = 0; i < 300; i++) begin
         s0[i] = 1'b1;
         s1[i] = 1'b1;
      end
      ri[1] = 8'h11; gi[1] = 8'h22; bi[1] = 8'h33;
      play(1, 255, 15, 1'b0);
      total++; if (ob_cv_cyc !== 255 + 2 + 15) begin bad++; $display("FAIL sat_latency got=%0d exp=%0d", ob_cv_cyc, 255 + 2 + 15); end
      total++; if (ob_c0 !== 8'(exp_cnt(0, 255, 15)) || ob_c1 !== 8'(exp_cnt(1, 255, 15))) begin bad++; $display("FAIL sat_cnt got=%0d/%0d exp=255/255", ob_c0, ob_c1); end
      total++; if (ob_cls !== 2'b01) begin bad++; $display("FAIL sat_cls got=%b exp=01", ob_cls); end
   endtask

   task automatic test_outside();
      int rep = 54;
      clear_pat();
      foreach (s0[i]) if (i == 0 || i == 1 || i >= rep) begin
         s0[i] = 1'b1;
         s1[i] = 1'b1;
      end
      ri[0] = 8'hC3; gi[0] = 8'h7E; bi[0] = 8'h01;
      play(0, 50, 2, 1'b1);
      total++; if (ob_cls !== 2'b00) begin bad++; $display("FAIL outside_cls got=%b exp=00", ob_cls); end
      total++; if (ob_c0 !== 8'(exp_cnt(0, 50, 2)) || ob_c1 !== 8'(exp_cnt(1, 50, 2))) begin bad++; $display("FAIL outside_cnt got=%0d/%0d exp=0/0", ob_c0, ob_c1); end
      total++; if (ob_hold_bad !== 0) begin bad++; $display("FAIL outside_hold got=%0d bad cycles exp=0", ob_hold_bad); end
      total++; if (ob_pulse_n !== 1 || ob_pulse1 !== 1'b1) begin bad++; $display("FAIL outside_pulses got=%0d cycles at1=%b exp=1/1", ob_pulse_n, ob_pulse1); end
      total++; if (ob_rdy_bad !== 0) begin bad++; $display("FAIL outside_ready got=%0d busy-ready cycles exp=0", ob_rdy_bad); end
      total++; if (ob_cv_cyc !== rep) begin bad++; $display("FAIL outside_latency got=%0d exp=%0d", ob_cv_cyc, rep); end
   endtask

   task automatic test_random();
      for (int w = 0; w < 4; w++) begin
         int e0, e1;
         clear_pat();
         rand_pat(0, 60, 8);
         ri[0] = 8'($urandom); gi[0] = 8'($urandom); bi[0] = 8'($urandom);
         play(0, 50, 2, 1'b0);
         e0 = exp_cnt(0, 50, 2);
         e1 = exp_cnt(1, 50, 2);
         total++; if (ob_cv_cyc !== 54 || ob_cv_n !== 1) begin bad++; $display("FAIL rand_strobe[%0d] got=%0d/%0d exp=54/1", w, ob_cv_cyc, ob_cv_n); end
         total++; if (ob_cls !== exp_cls(e0, e1)) begin bad++; $display("FAIL rand_cls[%0d] got=%b exp=%b", w, ob_cls, exp_cls(e0, e1)); end
         total++; if (ob_c0 !== 8'(e0) || ob_c1 !== 8'(e1)) begin bad++; $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d/%0d", w, ob_c0, ob_c1, e0, e1); end
         total++; if ({ob_cls_end, ob_c0_end, ob_c1_end} !== {exp_cls(e0, e1), 8'(e0), 8'(e1)}) begin bad++; $display("FAIL rand_hold_result[%0d] got=%b/%0d/%0d exp=%b/%0d/%0d", w, ob_cls_end, ob_c0_end, ob_c1_end, exp_cls(e0, e1), e0, e1); end
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      int e0, e1;
      ri[0] = 8'h99; gi[0] = 8'h88; bi[0] = 8'h77;
      for (int c = 0; c < 20; c++) begin
         pv[0] = (c == 0);
         o0[0] = 1'($urandom_range(0, 1));
         o1[0] = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (cv[0]) seen++;
         @(posedge clk);
         #1;
      end
      reset_n = 1'b0;
      #1;
      total++; if (pr[0] !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", pr[0]); end
      total++; if ({cl[0], c0[0], c1[0], rh[0], gh[0], bh[0]} !== 42'b0) begin bad++; $display("FAIL rstmid_zero got=%b/%0d/%0d/%h exp=0", cl[0], c0[0], c1[0], {rh[0], gh[0], bh[0]}); end
      repeat (3) begin
         @(negedge clk);
         if (cv[0]) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_strobe got=%0d exp=0", seen); end
      o0[0] = 1'b0;
      o1[0] = 1'b0;
      @(posedge clk);
      #1;
      clear_pat();
      rand_pat(0, 60, 6);
      ri[0] = 8'h12; gi[0] = 8'h34; bi[0] = 8'h56;
      reset_n = 1'b1;
      play(0, 50, 2, 1'b0);
      e0 = exp_cnt(0, 50, 2);
      e1 = exp_cnt(1, 50, 2);
      total++; if (ob_cv_cyc !== 54) begin bad++; $display("FAIL rstmid_latency got=%0d exp=54", ob_cv_cyc); end
      total++; if (ob_c0 !== 8'(e0) || ob_c1 !== 8'(e1) || ob_cls !== exp_cls(e0, e1)) begin bad++; $display("FAIL rstmid_result got=%b/%0d/%0d exp=%b/%0d/%0d", ob_cls, ob_c0, ob_c1, exp_cls(e0, e1), e0, e1); end
   endtask

   task automatic test_back_to_back();
      pv[2] = 1'b1;
      o0[2] = 1'b0;
      o1[2] = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         bit exp_v = (c >= 3) && ((c - 3) % 4 == 0);
         bit exp_r = (c % 4 == 0);
         @(negedge clk);
         total++; if (cv[2] !== exp_v) begin bad++; $display("FAIL b2b_valid[c=%0d] got=%b exp=%b", c, cv[2], exp_v); end
         total++; if (pr[2] !== exp_r) begin bad++; $display("FAIL b2b_ready[c=%0d] got=%b exp=%b", c, pr[2], exp_r); end
         if (exp_v) begin
            total++; if (cl[2] !== 2'b00) begin bad++; $display("FAIL b2b_cls[c=%0d] got=%b exp=00", c, cl[2]); end
         end
         @(posedge clk);
         #1;
      end
      pv[2] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_solid_blue();
      test_counts();
      test_saturate();
      test_outside();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
